// File: rtl/alu_arbiter_if.sv
// One requester's link to the shared ALU arbiter: an operation request
// channel and a held-response channel, each with valid/ready handshaking.
interface alu_arbiter_if #(
    parameter int W   = 32,
    parameter int OPW = 5
);
    logic           req_valid;
    logic           req_ready;
    logic [OPW-1:0] req_op;
    logic [W-1:0]   req_a;
    logic [W-1:0]   req_b;
    logic           req_lock;
    logic           rsp_valid;
    logic           rsp_ready;
    logic [W-1:0]   rsp_data;
    logic           rsp_err;

    modport master (
        output req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_lock, rsp_ready,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port round-robin arbiter with optional grant lock in front of one
// registered ALU; results return through per-port response holding registers.
module alu_arbiter #(
    parameter int W     = 32,
    parameter int OPW   = 5,
    parameter int MAXOP = 17
) (
    input  logic           clk,
    input  logic           rst,
    alu_arbiter_if.slave   p0,
    alu_arbiter_if.slave   p1,
    output logic [OPW-1:0] alu_op,
    output logic [W-1:0]   alu_op1,
    output logic [W-1:0]   alu_op2,
    input  logic [W-1:0]   alu_res
);
    typedef enum logic [1:0] {
        ARB     = 2'd0,
        LOCKED0 = 2'd1,
        LOCKED1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   last_q, last_d;
    logic   infl_v_q, infl_v_d;
    logic   infl_id_q, infl_id_d;
    logic   infl_err_q, infl_err_d;
    logic [1:0]        hold_v_q, hold_v_d;
    logic [1:0]        hold_err_q, hold_err_d;
    logic [1:0][W-1:0] hold_data_q, hold_data_d;

    logic [1:0] valid, rsp_rdy, lock, elig, cand, gnt;
    logic       issue, gid, illegal, land;
    logic [OPW-1:0] sel_op;

    always_comb begin
        valid   = {p1.req_valid, p0.req_valid};
        rsp_rdy = {p1.rsp_ready, p0.rsp_ready};
        lock    = {p1.req_lock,  p0.req_lock};

        // A port is blocked while its previous op is still in the ALU or its
        // held response cannot be freed this cycle.
        for (int i = 0; i < 2; i++) begin
            elig[i] = !(infl_v_q && (infl_id_q == 1'(i)))
                      && (!hold_v_q[i] || rsp_rdy[i]);
        end
        if (state_q == LOCKED0) elig[1] = 1'b0;
        if (state_q == LOCKED1) elig[0] = 1'b0;

        cand = valid & elig;
        if (cand == 2'b11) gnt = last_q ? 2'b01 : 2'b10;
        else               gnt = cand;
        issue = |gnt;
        gid   = gnt[1];

        sel_op  = gid ? p1.req_op : p0.req_op;
        illegal = sel_op > OPW'(MAXOP);

        alu_op  = '0;
        alu_op1 = '0;
        alu_op2 = '0;
        if (issue) begin
            alu_op  = illegal ? OPW'(1) : sel_op;
            alu_op1 = gid ? p1.req_a : p0.req_a;
            alu_op2 = gid ? p1.req_b : p0.req_b;
        end
    end

    // Next-state for arbitration/lock FSM and round-robin pointer.
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        if (issue) begin
            last_d = gid;
            case (state_q)
                ARB:     if (lock[gid]) state_d = gid ? LOCKED1 : LOCKED0;
                LOCKED0,
                LOCKED1: if (!lock[gid]) state_d = ARB;
                default: state_d = ARB;
            endcase
        end
    end

    always_comb begin
        infl_v_d   = issue;
        infl_id_d  = issue ? gid : 1'b0;
        infl_err_d = issue && illegal;

        hold_v_d    = hold_v_q;
        hold_err_d  = hold_err_q;
        hold_data_d = hold_data_q;
        for (int i = 0; i < 2; i++) begin
            land = infl_v_q && (infl_id_q == 1'(i));
            // A landing result takes priority over a drain on the same edge.
            if (land) begin
                hold_v_d[i]    = 1'b1;
                hold_err_d[i]  = infl_err_q;
                hold_data_d[i] = infl_err_q ? '0 : alu_res;
            end else if (hold_v_q[i] && rsp_rdy[i]) begin
                hold_v_d[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ARB;
            last_q      <= 1'b1;
            infl_v_q    <= 1'b0;
            infl_id_q   <= 1'b0;
            infl_err_q  <= 1'b0;
            hold_v_q    <= '0;
            hold_err_q  <= '0;
            hold_data_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            infl_v_q    <= infl_v_d;
            infl_id_q   <= infl_id_d;
            infl_err_q  <= infl_err_d;
            hold_v_q    <= hold_v_d;
            hold_err_q  <= hold_err_d;
            hold_data_q <= hold_data_d;
        end
    end

    assign p0.req_ready = gnt[0];
    assign p1.req_ready = gnt[1];
    assign p0.rsp_valid = hold_v_q[0];
    assign p1.rsp_valid = hold_v_q[1];
    assign p0.rsp_data  = hold_data_q[0];
    assign p1.rsp_data  = hold_data_q[1];
    assign p0.rsp_err   = hold_err_q[0];
    assign p1.rsp_err   = hold_err_q[1];
endmodule
